// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a downstream 4-bit universal shift register through
// one load / shift / capture sequence per start request. The register is
// parallel-loaded, shifted 'count' times in the requested direction with a
// serial fill bit, and its parallel output is captured into 'result'.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
module shift_sequencer (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       start,
  input  logic [3:0] data_in,
  input  logic       dir,
  input  logic [2:0] count,
  input  logic       fill,
  input  logic [3:0] A_par,
  output logic       s1,
  output logic       s0,
  output logic [3:0] I_par,
  output logic       MSB_in,
  output logic       LSB_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t     r_state;
  logic [1:0] r_mode;    // {s1,s0} for the state being entered
  logic [3:0] r_data;    // latched parallel load value
  logic       r_dir;     // latched direction, 1 = left
  logic [2:0] r_cnt;     // remaining shift cycles
  logic       r_msb;     // serial bit for right shifts
  logic       r_lsb;     // serial bit for left shifts
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_result;

  // Sequencer FSM: the mode, busy and done flops are written together with
  // the state they belong to, so they change on the same edge as the state.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_HOLD;
      r_data   <= 4'b0000;
      r_dir    <= 1'b0;
      r_cnt    <= 3'd0;
      r_msb    <= 1'b0;
      r_lsb    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // Latch the whole request so later input changes cannot leak in.
            r_data  <= data_in;
            r_dir   <= dir;
            r_cnt   <= count;
            r_msb   <= ~dir & fill;
            r_lsb   <= dir & fill;
            r_mode  <= MODE_LOAD;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end else begin
            r_mode  <= MODE_HOLD;
            r_busy  <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (r_cnt != 3'd0) begin
            r_mode  <= r_dir ? MODE_LEFT : MODE_RIGHT;
            r_state <= ST_SHIFT;
          end else begin
            // Nothing to shift: go straight to the capture cycle.
            r_mode  <= MODE_HOLD;
            r_state <= ST_CAPTURE;
          end
        end

        ST_SHIFT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_mode  <= MODE_HOLD;
            r_state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          // The register has been holding for this whole cycle, so A_par is
          // settled with the final shifted value.
          r_result <= A_par;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_mode  <= MODE_HOLD;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s1     = r_mode[1];
  assign s0     = r_mode[0];
  assign I_par  = r_data;
  assign MSB_in = r_msb;
  assign LSB_in = r_lsb;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioral model of the
// downstream 4-bit universal shift register closing the loop on A_par.
module tb_shift_sequencer;

  logic       CLK = 1'b0;
  logic       Clear;
  logic       start;
  logic [3:0] data_in;
  logic       dir;
  logic [2:0] count;
  logic       fill;
  logic [3:0] A_par = 4'b0000;
  logic       s1, s0;
  logic [3:0] I_par;
  logic       MSB_in, LSB_in, busy, done;
  logic [3:0] result;

  int errors = 0;
  int checks = 0;

  shift_sequencer dut (
    .CLK    (CLK),
    .Clear  (Clear),
    .start  (start),
    .data_in(data_in),
    .dir    (dir),
    .count  (count),
    .fill   (fill),
    .A_par  (A_par),
    .s1     (s1),
    .s0     (s0),
    .I_par  (I_par),
    .MSB_in (MSB_in),
    .LSB_in (LSB_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 CLK = ~CLK;

  // Downstream universal shift register (74194-style).
  always @(posedge CLK) begin
    case ({s1, s0})
      2'b11:   A_par <= I_par;
      2'b01:   A_par <= {MSB_in, A_par[3:1]};
      2'b10:   A_par <= {A_par[2:0], LSB_in};
      default: A_par <= A_par;
    endcase
  end

  typedef struct {
    logic [3:0] d;
    logic       dr;
    logic [2:0] c;
    logic       f;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full sequence, checking {s1,s0,busy,done,I_par,MSB_in,LSB_in} every
  // cycle; inputs are scrambled right after the request is taken.
  task automatic run_seq(input int idx, input vec_t v);
    logic [1:0] emode;
    logic       ebusy, edone;
    logic [9:0] exp_o;
    @(negedge CLK);
    data_in = v.d; dir = v.dr; count = v.c; fill = v.f; start = 1'b1;
    @(posedge CLK);
    for (int n = 0; n <= int'(v.c) + 3; n++) begin
      @(negedge CLK);
      emode = 2'b00; ebusy = 1'b0; edone = 1'b0;
      if (n == 0) begin
        emode = 2'b11; ebusy = 1'b1;
      end else if (n <= int'(v.c)) begin
        emode = v.dr ? 2'b10 : 2'b01; ebusy = 1'b1;
      end else if (n == int'(v.c) + 1) begin
        ebusy = 1'b1;
      end else if (n == int'(v.c) + 2) begin
        edone = 1'b1;
      end
      exp_o = {emode, ebusy, edone, v.d, ~v.dr & v.f, v.dr & v.f};
      check($sformatf("vec%0d_cyc%0d_outs", idx, n),
            {6'd0, s1, s0, busy, done, I_par, MSB_in, LSB_in}, {6'd0, exp_o});
      if (n == 0) begin
        start = 1'b0;
        data_in = ~v.d; dir = ~v.dr; count = ~v.c; fill = ~v.f;
      end
    end
    check($sformatf("vec%0d_result", idx), {12'd0, result}, {12'd0, v.exp_res});
  endtask

  initial begin
    int done_pulses;
    vec_t rv;

    vecs[0] = '{4'b1010, 1'b0, 3'd2, 1'b1, 4'b1110};
    vecs[1] = '{4'b0110, 1'b1, 3'd1, 1'b0, 4'b1100};
    vecs[2] = '{4'b1001, 1'b0, 3'd0, 1'b1, 4'b1001};
    vecs[3] = '{4'b1111, 1'b0, 3'd7, 1'b0, 4'b0000};
    vecs[4] = '{4'b0001, 1'b1, 3'd3, 1'b1, 4'b1111};
    vecs[5] = '{4'b1000, 1'b0, 3'd3, 1'b0, 4'b0001};
    vecs[6] = '{4'b0101, 1'b1, 3'd2, 1'b1, 4'b0111};

    Clear = 1'b1; start = 1'b0; data_in = 4'b0; dir = 1'b0; count = 3'd0; fill = 1'b0;
    #12;
    check("reset_outs", {2'd0, s1, s0, busy, done, I_par, MSB_in, LSB_in, result}, 16'd0);
    @(negedge CLK);
    Clear = 1'b0;

    // Idle without start stays idle.
    for (int i = 0; i < 3; i++) @(negedge CLK);
    check("idle_no_start", {12'd0, s1, s0, busy, done}, 16'd0);

    for (int i = 0; i < 7; i++) run_seq(i, vecs[i]);

    // Start pulses during SHIFT and during DONE are ignored.
    @(negedge CLK);
    data_in = 4'b1100; dir = 1'b0; count = 3'd2; fill = 1'b0; start = 1'b1;
    @(posedge CLK);
    done_pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (done) done_pulses++;
      if (n == 1) check("busy_start_in_shift_mode", {14'd0, s1, s0}, 16'h0001);
      if (n == 4) check("busy_start_done_cycle", {15'd0, done}, 16'h0001);
      start = (n == 1 || n == 4);
      data_in = (n == 1 || n == 4) ? 4'b1111 : 4'b1100;
    end
    start = 1'b0;
    check("busy_start_done_pulses", done_pulses[15:0], 16'd1);
    check("busy_start_idle_after", {14'd0, busy, done}, 16'd0);
    check("busy_start_result", {12'd0, result}, 16'h0003);
    check("busy_start_latch_kept", {12'd0, I_par}, 16'h000C);

    // Clear during the second SHIFT cycle.
    @(negedge CLK);
    data_in = 4'b1010; dir = 1'b0; count = 3'd5; fill = 1'b1; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0;   // LOAD
    @(negedge CLK);                 // first SHIFT
    @(negedge CLK);                 // second SHIFT
    check("clear_pre_mode", {14'd0, s1, s0}, 16'h0001);
    Clear = 1'b1;
    #1;
    check("clear_async_outs", {2'd0, s1, s0, busy, done, I_par, MSB_in, LSB_in, result}, 16'd0);
    done_pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      if (done) done_pulses++;
    end
    Clear = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      if (done) done_pulses++;
    end
    check("clear_no_done", done_pulses[15:0], 16'd0);
    check("clear_idle_busy", {15'd0, busy}, 16'd0);

    rv = '{4'b0011, 1'b0, 3'd0, 1'b0, 4'b0011};
    run_seq(7, rv);

    // result holds between captures.
    for (int n = 0; n < 5; n++) @(negedge CLK);
    check("result_hold", {12'd0, result}, 16'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
